// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM state type and access fault check shared by the load/store unit
package lsu_pkg;
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;
  typedef enum logic [2:0] {IDLE, REQ, RESP, DONE, FAULT} state_t;
  // funct3[1:0] encodes size for both loads and stores; bit 2 is only legal on byte/half loads
  function automatic logic lsu_fault(input logic ld, input logic [2:0] f3, input logic [1:0] a);
    return (ld ? (f3 == 3'b011 || f3[2:1] == 2'b11) : (f3[2] || f3[1:0] == 2'b11))
        || (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: data-memory request/grant/response bus
//   master drives req/we/addr/wdata/wstrb; slave returns gnt/rvalid/rdata
interface lsu_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  modport master(output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, input mem_gnt, mem_rvalid, mem_rdata);
  modport slave(input mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: store lane replication/strobes and load shift/extension
//   funct3/offset select lanes; store_data -> wdata/wstrb; rdata -> ldata
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] ldata
);
  logic [31:0] sh;
  always_comb begin
    sh = rdata >> {offset, 3'b000};
    wdata = funct3[1:0] == 2'b00 ? {4{store_data[7:0]}} : funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
    wstrb = funct3[1:0] == 2'b00 ? 4'b0001 << offset : funct3[1:0] == 2'b01 ? (offset[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    ldata = funct3 == LSU_B  ? {{24{sh[7]}}, sh[7:0]} :
            funct3 == LSU_H  ? {{16{sh[15]}}, sh[15:0]} :
            funct3 == LSU_BU ? {24'b0, sh[7:0]} :
            funct3 == LSU_HU ? {16'b0, sh[15:0]} : rdata;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory access engine
//   clk/rst_n; start/is_load/is_store/funct3/address/store_data from execute;
//   busy/done/fault/load_data to the core; mem is the data-memory bus master
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data,
  lsu_mem_if.master   mem
);
  state_t state, state_n;
  logic [31:0] addr_q, sd_q, wdata, ldata;
  logic [2:0] f3_q;
  logic [3:0] wstrb;
  logic ld_q, go, bad;
  assign go  = start && (is_load ^ is_store);
  assign bad = lsu_fault(is_load, funct3, address[1:0]);
  lsu_align u_align (
    .funct3(f3_q), .offset(addr_q[1:0]), .store_data(sd_q), .rdata(mem.mem_rdata),
    .wdata(wdata), .wstrb(wstrb), .ldata(ldata)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = go ? (bad ? FAULT : REQ) : IDLE;
      REQ:     state_n = mem.mem_gnt ? (ld_q ? RESP : DONE) : REQ;
      RESP:    state_n = mem.mem_rvalid ? DONE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q    <= '0;
      sd_q      <= '0;
      f3_q      <= '0;
      ld_q      <= 1'b0;
      load_data <= '0;
    end else begin
      if (state == IDLE && go && !bad) begin
        addr_q <= address;
        sd_q   <= store_data;
        f3_q   <= funct3;
        ld_q   <= is_load;
      end
      if (state == RESP && mem.mem_rvalid) load_data <= ldata;
    end
  // outputs decode only registered state, so they are glitch-free and drop with reset
  assign busy           = state != IDLE;
  assign done           = state == DONE || state == FAULT;
  assign fault          = state == FAULT;
  assign mem.mem_req    = state == REQ;
  assign mem.mem_we     = mem.mem_req && !ld_q;
  assign mem.mem_addr   = mem.mem_req ? {addr_q[31:2], 2'b00} : '0;
  assign mem.mem_wdata  = mem.mem_we ? wdata : '0;
  assign mem.mem_wstrb  = mem.mem_we ? wstrb : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench for load_store_unit
module tb_load_store_unit;
  import lsu_pkg::*;
  logic clk = 0, rst_n = 0, start = 0, is_load = 0, is_store = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] address = 0, store_data = 0, load_data;
  logic busy, done, fault;
  int checks = 0, failures = 0;
  logic [31:0] ld_model = 0;
  typedef struct { string tag; logic flt; logic [31:0] data; int lat; } exp_t;
  exp_t sb[$];
  lsu_mem_if bus();
  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .address(address), .store_data(store_data),
    .busy(busy), .done(done), .fault(fault), .load_data(load_data), .mem(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic access(input string tag, input logic ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd, input int gd, input int rdl,
                        input logic ef, input logic [31:0] ed, input logic [31:0] ew, input logic [3:0] es,
                        input logic poke);
    exp_t e;
    int cyc = 0, gcnt = 0, rcnt = 0;
    logic granted = 0;
    e.tag = tag;
    e.flt = ef;
    e.data = (ld && !ef) ? ed : ld_model;
    e.lat = ef ? 1 : ld ? 3 + gd + rdl : 2 + gd;
    ld_model = e.data;
    sb.push_back(e);
    start = 1; is_load = ld; is_store = !ld; funct3 = f3; address = a; store_data = sd;
    @(negedge clk);
    cyc = 1;
    while (cyc < 50) begin
      start = 0; is_load = 0; is_store = 0;
      bus.mem_gnt = 0; bus.mem_rvalid = 0;
      if (done) break;
      chk({tag, "_busy"}, busy, 1);
      if (ef) chk({tag, "_noreq"}, bus.mem_req, 0);
      if (bus.mem_req) begin
        chk({tag, "_addr"}, bus.mem_addr, {a[31:2], 2'b00});
        chk({tag, "_we"}, bus.mem_we, !ld);
        chk({tag, "_wdata"}, bus.mem_wdata, ew);
        chk({tag, "_wstrb"}, bus.mem_wstrb, es);
        if (poke && gcnt == 2) begin
          start = 1; is_load = 1; funct3 = LSU_W; address = 32'h5000;
        end
        if (gcnt == gd) begin bus.mem_gnt = 1; granted = 1; end
        gcnt++;
      end else if (granted && ld) begin
        if (rcnt == rdl) begin bus.mem_rvalid = 1; bus.mem_rdata = rd; end
        rcnt++;
      end
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done"}, done, 1);
    e = sb.pop_front();
    chk({e.tag, "_lat"}, cyc, e.lat);
    chk({e.tag, "_fault"}, fault, e.flt);
    chk({e.tag, "_data"}, load_data, e.data);
    chk({e.tag, "_busy_done"}, busy, 1);
    chk({e.tag, "_req_done"}, bus.mem_req, 0);
    @(negedge clk);
    chk({e.tag, "_done_pulse"}, done, 0);
    chk({e.tag, "_idle"}, busy, 0);
  endtask
  initial begin
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_data", load_data, 0);
    chk("rst_wstrb", bus.mem_wstrb, 0);
    rst_n = 1;
    @(negedge clk);
    start = 1; is_load = 1; is_store = 1; funct3 = LSU_W;
    @(negedge clk);
    start = 0; is_load = 0; is_store = 0;
    chk("both_flags_busy", busy, 0);
    chk("both_flags_req", bus.mem_req, 0);
    access("sb", 0, LSU_B, 32'h1003, 32'h000000AB, 0, 0, 0, 0, 0, 32'hABABABAB, 4'b1000, 0);
    access("lb", 1, LSU_B, 32'h2001, 0, 32'h1234F600, 0, 2, 0, 32'hFFFFFFF6, 0, 0, 0);
    access("lbu", 1, LSU_BU, 32'h2001, 0, 32'h1234F600, 0, 2, 0, 32'h000000F6, 0, 0, 0);
    access("lhu", 1, LSU_HU, 32'h2002, 0, 32'h8001ABCD, 0, 0, 0, 32'h00008001, 0, 0, 0);
    access("lh", 1, LSU_H, 32'h2002, 0, 32'h8001ABCD, 1, 0, 0, 32'hFFFF8001, 0, 0, 0);
    access("lw", 1, LSU_W, 32'h2000, 0, 32'h8001ABCD, 0, 1, 0, 32'h8001ABCD, 0, 0, 0);
    access("f_lw", 1, LSU_W, 32'h3002, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    access("f_sh", 0, LSU_H, 32'h3001, 32'h1234, 0, 0, 0, 1, 0, 0, 0, 0);
    access("f_f3", 1, 3'b011, 32'h3000, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    access("sh_stall", 0, LSU_H, 32'h1002, 32'h12345678, 0, 5, 0, 0, 0, 32'h56785678, 4'b1100, 1);
    access("sw", 0, LSU_W, 32'h1004, 32'hCAFEF00D, 0, 1, 0, 0, 0, 32'hCAFEF00D, 4'b1111, 0);
    chk("sb_empty", sb.size(), 0);
    start = 1; is_load = 1; funct3 = LSU_W; address = 32'h2000;
    @(negedge clk);
    start = 0; is_load = 0;
    chk("rst_mid_req", bus.mem_req, 1);
    bus.mem_gnt = 1;
    @(negedge clk);
    bus.mem_gnt = 0;
    chk("rst_mid_resp_busy", busy, 1);
    rst_n = 0;
    #1;
    chk("rst_async_busy", busy, 0);
    chk("rst_async_req", bus.mem_req, 0);
    chk("rst_async_addr", bus.mem_addr, 0);
    chk("rst_async_data", load_data, 0);
    chk("rst_async_done", done | fault, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    bus.mem_rvalid = 1; bus.mem_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.mem_rvalid = 0;
      chk("late_rvalid_done", done, 0);
      chk("late_rvalid_busy", busy, 0);
    end
    chk("late_rvalid_data", load_data, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
